// File: rtl/celda_serial_izqder.sv
// -----------------------------------------------------------------------------
// celda_serial_izqder
//
// Bit-serial, MSB-first (left-to-right) magnitude comparator cell. It stands in
// for a combinational chain of middle cells and walks through WIDTH bit pairs,
// one per accepted beat. The registered g_mid feeds the downstream final cell.
// The first bit pair that differs decides the result. Every pair after that is
// still consumed, but it leaves the flags untouched.
//
// Optional feature macro: COMPARE_SIGNED_EN
//   Defined   : operands are two's complement. If the first (sign) beat
//               differs, g_mid takes b_bit, because a negative sign means the
//               operand is the smaller one.
//   Undefined : unsigned comparison on every beat.
//
// Parameters
//   WIDTH : bit pairs per comparison (2..32)
//   CNT_W : beat-counter width, 2**CNT_W must exceed WIDTH
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   begin a new comparison (honoured in IDLE/DONE only)
//   bit_valid in   a_bit/b_bit carry a valid pair this cycle
//   a_bit     in   operand A bit, MSB first
//   b_bit     in   operand B bit, MSB first
//   bit_ready out  cell accepts a pair this cycle (RUN only)
//   busy      out  comparison in progress
//   done      out  one-cycle pulse once the last pair has been consumed
//   g_mid     out  registered A>B flag
//   e_mid     out  registered A==B flag
// -----------------------------------------------------------------------------
module celda_serial_izqder #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic bit_ready,
  output logic busy,
  output logic done,
  output logic g_mid,
  output logic e_mid
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg,   cnt_next;
  logic             bit_ready_next;
  logic             busy_next;
  logic             done_next;
  logic             g_next;
  logic             e_next;

  logic             beat;
  logic             div_g;

  // bit_ready is registered and high only in RUN, so it qualifies beats by itself.
  assign beat = bit_valid && bit_ready;

  // Value g_mid takes at the first differing pair.
`ifdef COMPARE_SIGNED_EN
  // On the sign beat a set bit marks the smaller operand, so B's bit decides.
  assign div_g = (cnt_reg == '0) ? b_bit : a_bit;
`else
  assign div_g = a_bit;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      bit_ready <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      g_mid     <= 1'b0;
      e_mid     <= 1'b1;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      bit_ready <= bit_ready_next;
      busy      <= busy_next;
      done      <= done_next;
      g_mid     <= g_next;
      e_mid     <= e_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    cnt_next       = cnt_reg;
    bit_ready_next = bit_ready;
    busy_next      = busy;
    done_next      = 1'b0;
    g_next         = g_mid;
    e_next         = e_mid;

    case (state_reg)
      IDLE, DONE: begin
        // A pair presented in the start cycle is ignored because bit_ready is still low.
        if (start) begin
          state_next     = RUN;
          cnt_next       = '0;
          g_next         = 1'b0;
          e_next         = 1'b1;
          busy_next      = 1'b1;
          bit_ready_next = 1'b1;
        end
      end

      RUN: begin
        // start is ignored here: a comparison cannot be aborted or restarted.
        if (beat) begin
          if (e_mid && (a_bit != b_bit)) begin
            e_next = 1'b0;
            g_next = div_g;
          end
          if (cnt_reg == LAST_CNT) begin
            // The counter holds at WIDTH-1, so it never wraps.
            state_next     = DONE;
            busy_next      = 1'b0;
            bit_ready_next = 1'b0;
            done_next      = 1'b1;
          end else begin
            cnt_next = cnt_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next     = IDLE;
        cnt_next       = '0;
        bit_ready_next = 1'b0;
        busy_next      = 1'b0;
        g_next         = 1'b0;
        e_next         = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_celda_serial_izqder.sv
// -----------------------------------------------------------------------------
// tb_celda_serial_izqder
//
// Self-checking bench for celda_serial_izqder (WIDTH=8). The reference result
// is an ordinary integer comparison of the whole words: signed when
// COMPARE_SIGNED_EN is defined, unsigned otherwise. Each scenario task drives
// its own stimulus and checks the results inline.
// -----------------------------------------------------------------------------
module tb_celda_serial_izqder;

  localparam int W = 8;

  logic clk;
  logic rst_n;
  logic start;
  logic bit_valid;
  logic a_bit;
  logic b_bit;
  logic bit_ready;
  logic busy;
  logic done;
  logic g_mid;
  logic e_mid;

  int pass_cnt  = 0;
  int total_cnt = 0;

  celda_serial_izqder #(.WIDTH(W), .CNT_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .bit_valid (bit_valid),
    .a_bit     (a_bit),
    .b_bit     (b_bit),
    .bit_ready (bit_ready),
    .busy      (busy),
    .done      (done),
    .g_mid     (g_mid),
    .e_mid     (e_mid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Whole-word reference: A greater than B.
  function automatic logic ref_gt(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef COMPARE_SIGNED_EN
    return ($signed(a) > $signed(b));
`else
    return (a > b);
`endif
  endfunction

  // Results captured by run_compare.
  logic s_g, s_e, s_busy, s_ready;
  logic f_done, f_busy, f_ready, f_g, f_e;
  int   early_done, not_ready, cycles;
  bit   timeout;

  // Streams one comparison, MSB first. Inputs are driven on negedges.
  // stall_mode: 0 no stalls, 1 bit_valid low every other cycle, 2 random stalls.
  // noise: present a differing pair alongside start; it must be ignored.
  // start_mid: raise start along with beat 4; it must be ignored.
  task automatic run_compare(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int stall_mode, input bit noise, input bit start_mid);
    int  beats;
    bit  v;
    @(negedge clk);
    start     = 1'b1;
    bit_valid = noise;
    a_bit     = 1'b1;
    b_bit     = 1'b0;
    @(negedge clk);
    start   = 1'b0;
    s_g     = g_mid;
    s_e     = e_mid;
    s_busy  = busy;
    s_ready = bit_ready;
    beats = 0; early_done = 0; not_ready = 0; cycles = 0; timeout = 0;
    while (beats < W && !timeout) begin
      if (bit_ready !== 1'b1) not_ready++;
      if (done !== 1'b0) early_done++;
      case (stall_mode)
        0:       v = 1'b1;
        1:       v = (cycles % 2) == 1;
        default: v = ($urandom_range(0, 2) != 0);
      endcase
      bit_valid = v;
      a_bit     = v ? a[W-1-beats] : 1'($urandom);
      b_bit     = v ? b[W-1-beats] : 1'($urandom);
      start     = start_mid && (beats == 4);
      @(negedge clk);
      if (v) beats++;
      cycles++;
      if (cycles > 100) timeout = 1;
    end
    start     = 1'b0;
    bit_valid = 1'b0;
    f_done  = done;
    f_busy  = busy;
    f_ready = bit_ready;
    f_g     = g_mid;
    f_e     = e_mid;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; bit_valid = 1'b0; a_bit = 1'b0; b_bit = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total_cnt++; if ({g_mid, e_mid, busy, done, bit_ready} !== 5'b01000)
      $display("FAIL reset_values got=%b exp=01000", {g_mid, e_mid, busy, done, bit_ready});
    else pass_cnt++;
    // A differing pair offered in IDLE must change nothing.
    bit_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0;
    repeat (3) @(negedge clk);
    bit_valid = 1'b0;
    total_cnt++; if ({g_mid, e_mid, busy, done, bit_ready} !== 5'b01000)
      $display("FAIL idle_ignores_bits got=%b exp=01000", {g_mid, e_mid, busy, done, bit_ready});
    else pass_cnt++;
    $display("test_reset done");
  endtask

  task automatic test_directed();
    logic [W-1:0] av [4] = '{8'hA5, 8'h3C, 8'h01, 8'hFF};
    logic [W-1:0] bv [4] = '{8'hA4, 8'h3C, 8'h80, 8'h01};
    for (int i = 0; i < 4; i++) begin
      run_compare(av[i], bv[i], 0, 1'b0, 1'b0);
      $display("directed A=%02h B=%02h g=%b e=%b cycles=%0d", av[i], bv[i], f_g, f_e, cycles);
      total_cnt++; if (s_busy !== 1'b1 || s_ready !== 1'b1)
        $display("FAIL start_handshake busy=%b ready=%b exp=1/1", s_busy, s_ready);
      else pass_cnt++;
      total_cnt++; if (f_done !== 1'b1 || early_done != 0 || f_busy !== 1'b0 || f_ready !== 1'b0)
        $display("FAIL done_timing done=%b early=%0d busy=%b ready=%b exp=1/0/0/0", f_done, early_done, f_busy, f_ready);
      else pass_cnt++;
      total_cnt++; if (cycles != W || timeout)
        $display("FAIL min_latency cycles=%0d exp=%0d", cycles, W);
      else pass_cnt++;
      total_cnt++; if ({f_g, f_e} !== {ref_gt(av[i], bv[i]), av[i] == bv[i]})
        $display("FAIL result_%02h_%02h got=%b%b exp=%b%b", av[i], bv[i], f_g, f_e, ref_gt(av[i], bv[i]), av[i] == bv[i]);
      else pass_cnt++;
    end
  endtask

  task automatic test_stalls();
    run_compare(8'hF0, 8'h0F, 1, 1'b0, 1'b0);
    $display("stalls A=F0 B=0F g=%b e=%b cycles=%0d", f_g, f_e, cycles);
    total_cnt++; if (cycles != 2*W || f_done !== 1'b1 || early_done != 0)
      $display("FAIL stall_timing cycles=%0d done=%b early=%0d exp=16/1/0", cycles, f_done, early_done);
    else pass_cnt++;
    total_cnt++; if ({f_g, f_e} !== {ref_gt(8'hF0, 8'h0F), 1'b0})
      $display("FAIL stall_result got=%b%b exp=%b0", f_g, f_e, ref_gt(8'hF0, 8'h0F));
    else pass_cnt++;
    total_cnt++; if (not_ready != 0)
      $display("FAIL stall_ready not_ready=%0d exp=0", not_ready);
    else pass_cnt++;
  endtask

  task automatic test_hold_done();
    logic g0, e0;
    int bad;
    run_compare(8'h7E, 8'h7C, 0, 1'b0, 1'b0);
    g0 = f_g; e0 = f_e; bad = 0;
    // A differing pair offered in DONE must neither change the flags nor retrigger done.
    for (int i = 0; i < 6; i++) begin
      bit_valid = 1'b1; a_bit = 1'($urandom); b_bit = ~a_bit;
      @(negedge clk);
      if (g_mid !== g0 || e_mid !== e0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    bit_valid = 1'b0;
    $display("hold_done g=%b e=%b bad=%0d", g0, e0, bad);
    total_cnt++; if (bad != 0 || {g0, e0} !== {ref_gt(8'h7E, 8'h7C), 1'b0})
      $display("FAIL hold_in_done bad=%0d g=%b e=%b exp=0 %b0", bad, g0, e0, ref_gt(8'h7E, 8'h7C));
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    // Start straight from DONE, with noise in the start cycle and a start mid-run.
    run_compare(8'hC3, 8'h5A, 0, 1'b0, 1'b0);
    run_compare(8'h5A, 8'h5B, 0, 1'b1, 1'b1);
    $display("back_to_back A=5A B=5B g=%b e=%b", f_g, f_e);
    total_cnt++; if (s_g !== 1'b0 || s_e !== 1'b1)
      $display("FAIL restart_clear got=%b%b exp=01", s_g, s_e);
    else pass_cnt++;
    total_cnt++; if ({f_g, f_e, f_done} !== {ref_gt(8'h5A, 8'h5B), 1'b0, 1'b1} || cycles != W)
      $display("FAIL b2b_result got=%b%b%b cycles=%0d exp=%b01 %0d", f_g, f_e, f_done, cycles, ref_gt(8'h5A, 8'h5B), W);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int dpulse;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1; a_bit = (i == 0); b_bit = 1'b0;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    $display("reset_mid g=%b e=%b busy=%b", g_mid, e_mid, busy);
    total_cnt++; if ({g_mid, e_mid, busy, done, bit_ready} !== 5'b01000)
      $display("FAIL async_reset got=%b exp=01000", {g_mid, e_mid, busy, done, bit_ready});
    else pass_cnt++;
    dpulse = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 1) rst_n = 1'b1;
      if (done !== 1'b0) dpulse++;
    end
    total_cnt++; if (dpulse != 0 || busy !== 1'b0)
      $display("FAIL reset_no_done pulses=%0d busy=%b exp=0/0", dpulse, busy);
    else pass_cnt++;
    run_compare(8'h12, 8'h34, 0, 1'b0, 1'b0);
    total_cnt++; if ({f_g, f_e, f_done} !== {ref_gt(8'h12, 8'h34), 1'b0, 1'b1})
      $display("FAIL after_reset got=%b%b%b exp=%b01", f_g, f_e, f_done, ref_gt(8'h12, 8'h34));
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [W-1:0] a, b;
    for (int i = 0; i < 24; i++) begin
      a = 8'($urandom);
      b = (i % 4 == 0) ? a : ((i % 4 == 1) ? (a ^ 8'(1 << $urandom_range(0, 7))) : 8'($urandom));
      run_compare(a, b, 2, 1'($urandom), 1'($urandom));
      $display("random A=%02h B=%02h g=%b e=%b cycles=%0d", a, b, f_g, f_e, cycles);
      total_cnt++; if ({f_g, f_e, f_done} !== {ref_gt(a, b), a == b, 1'b1} || early_done != 0 || timeout)
        $display("FAIL rand_%02h_%02h got=%b%b%b early=%0d exp=%b%b1", a, b, f_g, f_e, f_done, early_done, ref_gt(a, b), a == b);
      else pass_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stalls();
    test_hold_done();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/celda_serial_izqder.md
Name: celda_serial_izqder

Overview:
- Bit-serial, left-to-right (MSB-first) magnitude-comparison chain.
- Replaces the combinational array of middle cells with a single sequential cell that iterates over WIDTH bit pairs.
- Drives g_mid directly into the downstream final cell (input g_mid, output f). Also exports an equality flag and a done strobe.
- Consumes one (a_bit, b_bit) pair per accepted beat.

Parameters:
- WIDTH, 8, number of bit pairs per comparison (2..32).
- CNT_W, 5, bit-counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  begin new comparison; sampled only in IDLE or DONE.
- bit_valid  input  1  a_bit/b_bit are valid this cycle.
- a_bit  input  1  current bit of operand A, MSB first.
- b_bit  input  1  current bit of operand B, MSB first.
- bit_ready  output  1  cell accepts a bit pair this cycle (high only in RUN).
- busy  output  1  comparison in progress.
- done  output  1  one-cycle pulse when the final bit has been consumed.
- g_mid  output  1  registered A>B flag, feeds the final cell.
- e_mid  output  1  registered A==B flag.

Behaviour:
- Single clock domain.
- Reset is asynchronous, active-low on rst_n. All outputs are registered.
- Reset values: state=IDLE, cnt=0, bit_ready=0, busy=0, done=0, g_mid=0, e_mid=1.
- FSM states: IDLE, RUN, DONE.
  - IDLE --start--> RUN.
  - RUN --last bit accepted--> DONE.
  - DONE --start--> RUN.
  - DONE with no start --> stays DONE, holds g_mid/e_mid.
- Start handling (in IDLE or DONE):
  - start=1 clears cnt=0, g_mid=0, e_mid=1.
  - Sets busy=1 and bit_ready=1 next cycle.
  - Any bit_valid in that same cycle is ignored.
- Beat acceptance: bit_valid && bit_ready. Per accepted beat:
  - If e_mid=1 and a_bit!=b_bit: e_mid<=0, g_mid<=a_bit.
  - If e_mid=0: g_mid and e_mid are frozen. The first differing bit from the left decides.
  - cnt increments by 1.
- bit_valid=0 in RUN: stall. No state change, no counting.
- Final beat: the beat accepted with cnt==WIDTH-1:
  - Next cycle: state=DONE, busy=0, bit_ready=0, done=1 for exactly one cycle.
  - g_mid/e_mid reflect the full word on the same edge that asserts done (latency 1 cycle after last beat; WIDTH cycles minimum per comparison).
- g_mid stays stable during DONE so the final cell's f is valid until the next start.
- start while in RUN is ignored. No restart and no abort.
- rst_n asserted mid-comparison: immediate return to reset values. Partial result discarded. done not pulsed.
- bit_valid in IDLE/DONE: ignored.
- cnt never exceeds WIDTH-1. Wrap-around is impossible because RUN exits on the last beat.

Optional Feature:
- Macro: COMPARE_SIGNED_EN.
- Defined: operands are two's complement. On the first beat (cnt==0), a differing pair sets g_mid<=b_bit instead of a_bit, because a negative sign bit means smaller. Later beats behave unsigned.
- Undefined: purely unsigned comparison on all beats. No extra logic.

Test Plan:
- Reset then idle: rst_n low 2 cycles, then high -> g_mid=0, e_mid=1, busy=0, done=0, bit_ready=0.
- Unsigned A=8'hA5, B=8'h A4 streamed with bit_valid held 1 -> done pulses 1 cycle after beat 8; g_mid=1, e_mid=0.
- A=B=8'h3C -> done after 8 beats; g_mid=0, e_mid=1. Then start again with A=8'h01, B=8'h80 -> g_mid=0, e_mid=0.
- Stalls: A=8'hF0, B=8'h0F with bit_valid low every other cycle -> done occurs after the 8th accepted beat (~16 cycles); g_mid=1.
- Reset mid-operation: rst_n pulsed low after 3 beats -> outputs return to reset values; no done pulse. A fresh comparison then completes correctly.
- COMPARE_SIGNED_EN defined: A=8'hFF (-1), B=8'h01 -> g_mid=0, e_mid=0. With the macro undefined, same stimulus -> g_mid=1.
